// File: rtl/golomb_bit_packer_pkg.sv
// golomb_bit_packer_pkg: shared constants and state encoding for the Golomb bit packer
package golomb_bit_packer_pkg;
    localparam int DEF_LIMIT = 32;
    localparam int DEF_QBPP  = 8;
    localparam int K_MAX     = 14;
    localparam int ESC_ZEROS = DEF_LIMIT - DEF_QBPP - 1;

    typedef enum logic [1:0] {IDLE, ZEROS, SUFFIX, FLUSH} state_t;

    function automatic int sfx_max(input int qbpp);
        return qbpp > K_MAX ? qbpp : K_MAX;
    endfunction
endpackage

// File: rtl/golomb_code_former.sv
// golomb_code_former: splits (merrval, k) into unary zero run and binary suffix, escape included
module golomb_code_former
    import golomb_bit_packer_pkg::*;
#(
    parameter int MERR_WIDTH = 16,
    parameter int K_WIDTH    = 4,
    parameter int LIMIT      = DEF_LIMIT,
    parameter int QBPP       = DEF_QBPP,
    parameter int ZW         = 5,
    parameter int SFW        = 14,
    parameter int LW         = 4
) (
    input  logic [MERR_WIDTH-1:0] merrval,
    input  logic [K_WIDTH-1:0]    k,
    output logic [ZW-1:0]         zero_count,
    output logic [SFW-1:0]        suffix_val,
    output logic [LW-1:0]         suffix_len
);
    localparam int ESC = LIMIT - QBPP - 1;

    logic [MERR_WIDTH-1:0] q, kmask, emask, m1;
    logic                  esc;

    always_comb begin
        q          = merrval >> k;
        esc        = q >= MERR_WIDTH'(ESC);
        kmask      = ~({MERR_WIDTH{1'b1}} << k);
        emask      = ~({MERR_WIDTH{1'b1}} << QBPP);
        m1         = merrval - MERR_WIDTH'(1);
        zero_count = esc ? ZW'(ESC) : ZW'(q);
        suffix_val = esc ? SFW'(m1 & emask) : SFW'(merrval & kmask);
        suffix_len = esc ? LW'(QBPP) : LW'(k);
    end
endmodule

// File: rtl/golomb_bit_packer.sv
// golomb_bit_packer: JPEG-LS limited-length Golomb codeword packer into a 0xFF-stuffed byte stream
module golomb_bit_packer
    import golomb_bit_packer_pkg::*;
#(
    parameter int MERR_WIDTH = 16,
    parameter int K_WIDTH    = 4,
    parameter int LIMIT      = DEF_LIMIT,
    parameter int QBPP       = DEF_QBPP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MERR_WIDTH-1:0] merrval,
    input  logic [K_WIDTH-1:0]    k,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  flush_done
);
    localparam int ESC = LIMIT - QBPP - 1;
    localparam int SW  = sfx_max(QBPP) + 1;
    localparam int ZW  = $clog2(ESC + 1);
    localparam int LW  = $clog2(SW + 1);

    state_t        state_q, state_d;
    logic [ZW-1:0] zr_q, zr_d, zc;
    logic [SW-1:0] sv_q, sv_d, chunk;
    logic [SW-2:0] sfx;
    logic [LW-1:0] sl_q, sl_d, sfx_len;
    logic [7:0]    acc_q, acc_d, byte_q, byte_d, tmp, raw, nb, rem;
    logic [3:0]    cnt_q, cnt_d, cap, free, n;
    logic          stuff_q, stuff_d, ov_q, ov_d, pend_q, pend_d;
    logic          can_out, accept, done, mv, full, pad, wr;

    golomb_code_former #(
        .MERR_WIDTH(MERR_WIDTH), .K_WIDTH(K_WIDTH), .LIMIT(LIMIT), .QBPP(QBPP),
        .ZW(ZW), .SFW(SW - 1), .LW(LW)
    ) u_former (
        .merrval(merrval), .k(k), .zero_count(zc), .suffix_val(sfx), .suffix_len(sfx_len)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            zr_q    <= '0;
            sv_q    <= '0;
            sl_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            stuff_q <= 1'b0;
            ov_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zr_q    <= zr_d;
            sv_q    <= sv_d;
            sl_q    <= sl_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            stuff_q <= stuff_d;
            ov_q    <= ov_d;
            pend_q  <= pend_d;
        end
    end

    // Bits only move when the byte they might complete has somewhere to go.
    always_comb begin
        can_out = !ov_q || out_ready;
        accept  = in_valid && in_ready;
        done    = cnt_q == 4'd0 && !ov_q;
        cap     = stuff_q ? 4'd7 : 4'd8;
        free    = cap - cnt_q;
        rem     = state_q == ZEROS ? 8'(zr_q) : 8'(sl_q);
        n       = rem < 8'(free) ? rem[3:0] : free;
        mv      = can_out && (state_q == ZEROS || state_q == SUFFIX);
        full    = cnt_q + n == cap;
        chunk   = state_q == SUFFIX ? (sv_q >> (sl_q - LW'(n))) & ~({SW{1'b1}} << n) : '0;
        tmp     = (acc_q << n) | 8'(chunk);
        pad     = state_q == FLUSH && can_out && cnt_q != 4'd0;
        wr      = (mv && full) || pad;
        raw     = pad ? acc_q << (cap - cnt_q) : tmp;
        nb      = stuff_q ? {1'b0, raw[6:0]} : raw;
        ov_d    = wr || (ov_q && !out_ready);
        byte_d  = wr ? nb : byte_q;
        stuff_d = wr ? nb == 8'hFF : stuff_q;
        acc_d   = wr ? 8'd0 : mv ? tmp : acc_q;
        cnt_d   = wr ? 4'd0 : mv ? cnt_q + n : cnt_q;
        zr_d    = accept ? zc : (mv && state_q == ZEROS) ? zr_q - ZW'(n) : zr_q;
        sv_d    = accept ? SW'(sfx) | (SW'(1) << sfx_len) : sv_q;
        sl_d    = accept ? sfx_len + LW'(1) : (mv && state_q == SUFFIX) ? sl_q - LW'(n) : sl_q;
        pend_d  = (state_q == ZEROS || state_q == SUFFIX) ? pend_q || flush : accept && flush;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (zc == '0 ? SUFFIX : ZEROS) : (flush || pend_q) ? FLUSH : IDLE;
            ZEROS:   if (mv && zr_q == ZW'(n)) state_d = SUFFIX;
            SUFFIX:  if (mv && sl_q == LW'(n)) state_d = IDLE;
            default: if (done) state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = rst_n && state_q == IDLE && !pend_q;
        flush_done = rst_n && state_q == FLUSH && done;
        out_valid  = ov_q;
        out_byte   = byte_q;
    end
endmodule

// File: doc/golomb_bit_packer.md
Name: golomb_bit_packer

Overview:
- Downstream consumer of the k-parameter stage.
- Takes one mapped error value (MErrval) plus its Golomb parameter k per accepted transaction and forms the JPEG-LS limited-length Golomb codeword.
- Packs codewords MSB-first into an 8-bit byte stream, applying 0xFF bit-stuffing, with valid/ready handshakes on both sides.
- Output feeds the marker/stream writer.

Parameters:
MERR_WIDTH, 16, width of MErrval input
K_WIDTH, 4, width of k input (k max 14)
LIMIT, 32, JPEG-LS LIMIT (total codeword length cap)
QBPP, 8, bits per escaped sample value

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  merrval/k valid
in_ready  output  1  block can accept a codeword this cycle
merrval  input  MERR_WIDTH  mapped error value (non-negative)
k  input  K_WIDTH  Golomb parameter from k stage
flush  input  1  pulse: pad and emit any partial byte once idle
out_valid  output  1  out_byte valid
out_ready  input  1  downstream accepts byte
out_byte  output  8  packed stream byte
flush_done  output  1  one-cycle pulse when flush is complete

Behaviour:
- Reset (rst_n=0 at a clock edge), effective mid-operation too:
  - out_valid=0, out_byte=0x00, in_ready=0 during reset, flush_done=0.
  - Accumulator cleared; stuff flag cleared; state=IDLE.
  - Partially emitted codewords are discarded.
- Codeword forming, combinational at acceptance:
  - q = merrval >> k.
  - If q < LIMIT-QBPP-1 (23 by default): q zeros, a '1', then the k LSBs of merrval.
  - Otherwise (escape): LIMIT-QBPP-1 zeros, a '1', then QBPP LSBs of (merrval-1).
  - k=0 gives an empty suffix.
- State machine: IDLE, ZEROS, SUFFIX, FLUSH.
  - IDLE: in_ready=1 when no flush is pending. in_valid&in_ready latches zero count, suffix value and suffix length, then goes to ZEROS, or to SUFFIX if the zero count is 0.
  - ZEROS: each cycle moves min(free accumulator bits, remaining zeros) into the accumulator. Goes to SUFFIX when remaining=0.
  - SUFFIX: moves the '1' plus suffix bits, up to the free-bit count per cycle. Returns to IDLE when all bits are moved.
  - FLUSH: entered from IDLE when flush is seen, or when a flush arrives mid-codeword (latched; taken after the codeword completes).
    - A nonempty accumulator is zero-padded and emitted.
    - An empty accumulator emits nothing.
    - flush_done pulses the cycle after the final byte handshakes (or immediately if empty), then returns to IDLE.
- Byte formation:
  - Capacity is 8 data bits normally.
  - If the previous emitted byte was 0xFF, capacity is 7 and the byte MSB is a forced 0.
- Output register:
  - A byte completes into the output register when the register is empty, or when it is being taken the same cycle (out_valid&out_ready).
  - Otherwise the accumulator stalls and no bits move. out_byte stays stable while out_valid&!out_ready.
  - Sustained throughput is at most 1 byte/cycle.
- in_ready is 0 outside IDLE, so a codeword is fully moved into the accumulator before the next is accepted.
- Simultaneous flush and in_valid in IDLE: the codeword is accepted first, and the flush is latched behind it.

Decomposition:
- Shared package: LIMIT/QBPP defaults, derived ESC_ZEROS=LIMIT-QBPP-1, maximum suffix width (max(14,QBPP)), state encoding constants.
- One sub-module: golomb_code_former (combinational). Inputs merrval and k; outputs zero_count, suffix_val and suffix_len, including the escape decision.

Test Plan:
- merrval=5, k=1, then flush, out_ready=1 -> bytes 0x30; flush_done pulses once.
- merrval=200, k=0 (escape), then flush -> 0x00, 0x00, 0x01, 0xC7; no pad byte.
- merrval=127, k=7 twice, then flush -> 0xFF, 0x7F (stuffed MSB 0), 0x80.
- Same stimulus as scenario 2 with out_ready low for 5 cycles after the first out_valid -> out_byte holds 0x00 stable, in_ready stays 0, byte sequence unchanged.
- Reset (rst_n=0) asserted while in ZEROS of an escape code -> next cycle out_valid=0, in_ready=0. After release, a fresh merrval=5, k=1 plus flush -> only 0x30.
- flush with empty accumulator in IDLE -> no out_valid, flush_done pulses the next cycle.
